// File: rtl/sincronizador_filtrado_if.sv
// Receiver-side bundle for the multi-channel synchroniser: enable, raw lines in,
// filtered level and edge pulses out.
interface sincronizador_filtrado_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             enb;
  logic [WIDTH-1:0] dataAsync;
  logic [WIDTH-1:0] dataSync;
  logic [WIDTH-1:0] risePulse;
  logic [WIDTH-1:0] fallPulse;
  logic             anyChange;

  modport master (
    output enb,
    output dataAsync,
    input  dataSync,
    input  risePulse,
    input  fallPulse,
    input  anyChange
  );

  modport slave (
    input  enb,
    input  dataAsync,
    output dataSync,
    output risePulse,
    output fallPulse,
    output anyChange
  );
endinterface

// File: rtl/sincronizador_filtrado.sv
// Multi-channel flop-chain synchroniser followed by a per-channel consecutive-sample
// glitch filter, with registered rise/fall pulses aligned to the filtered level.
module sincronizador_filtrado #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned STAGES  = 2,
  parameter int unsigned FILTER  = 3,
  parameter bit          RST_VAL = 1'b0
) (
  input logic                    clkRx,
  input logic                    rst,
  sincronizador_filtrado_if.slave bus
);

  localparam int unsigned CW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [CW-1:0] CntMax = CW'(FILTER - 1);

  if (STAGES < 2) begin : g_bad_stages
    $error("sincronizador_filtrado: STAGES must be at least 2");
  end
  if (FILTER < 1) begin : g_bad_filter
    $error("sincronizador_filtrado: FILTER must be at least 1");
  end

  logic [WIDTH-1:0] chain [STAGES];
  logic [CW-1:0]    cnt   [WIDTH];
  logic [WIDTH-1:0] syncRaw;
  logic [WIDTH-1:0] upd;
  logic [WIDTH-1:0] dataSync;
  logic [WIDTH-1:0] risePulse;
  logic [WIDTH-1:0] fallPulse;
  logic             anyChange;

  assign syncRaw = chain[STAGES-1];

  // A channel flips when it has disagreed for FILTER consecutive enabled samples.
  always_comb begin
    upd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      upd[i] = (syncRaw[i] != dataSync[i]) && (cnt[i] == CntMax);
    end
  end

  always_ff @(posedge clkRx or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        chain[k] <= {WIDTH{RST_VAL}};
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
      dataSync  <= {WIDTH{RST_VAL}};
      risePulse <= '0;
      fallPulse <= '0;
      anyChange <= 1'b0;
    end else if (bus.enb) begin
      chain[0] <= bus.dataAsync;
      for (int k = 1; k < STAGES; k++) begin
        chain[k] <= chain[k-1];
      end
      for (int i = 0; i < WIDTH; i++) begin
        if ((syncRaw[i] == dataSync[i]) || upd[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
      dataSync  <= dataSync ^ upd;
      risePulse <= upd & syncRaw;
      fallPulse <= upd & ~syncRaw;
      anyChange <= |upd;
    end else begin
      // Disabled: hold chain, counts and level; pulses drop.
      risePulse <= '0;
      fallPulse <= '0;
      anyChange <= 1'b0;
    end
  end

  assign bus.dataSync  = dataSync;
  assign bus.risePulse = risePulse;
  assign bus.fallPulse = fallPulse;
  assign bus.anyChange = anyChange;

endmodule

// File: tb/tb_sincronizador_filtrado.sv
// Bench for sincronizador_filtrado: directed scenarios plus random stimulus, both
// DUT configurations compared every edge against a sample-history reference model.
module tb_sincronizador_filtrado;

  logic       clkRx = 1'b0;
  logic       rst   = 1'b0;
  logic       enb   = 1'b1;
  logic [7:0] dataA = 8'h00;
  logic [3:0] dataB = 4'h0;

  int errors = 0;
  int checks = 0;

  always #5 clkRx = ~clkRx;

  sincronizador_filtrado_if #(.WIDTH(8)) busA ();
  sincronizador_filtrado_if #(.WIDTH(4)) busB ();

  assign busA.enb       = enb;
  assign busA.dataAsync = dataA;
  assign busB.enb       = enb;
  assign busB.dataAsync = dataB;

  sincronizador_filtrado #(.WIDTH(8), .STAGES(2), .FILTER(3), .RST_VAL(1'b0)) dutA (
    .clkRx (clkRx),
    .rst   (rst),
    .bus   (busA.slave)
  );

  sincronizador_filtrado #(.WIDTH(4), .STAGES(3), .FILTER(1), .RST_VAL(1'b0)) dutB (
    .clkRx (clkRx),
    .rst   (rst),
    .bus   (busB.slave)
  );

  // Reference model: per DUT, the history of enabled input samples since reset and
  // the history of synchronised values those samples produce.
  localparam int HMASK = 1023;
  int         stg [2] = '{2, 3};
  int         flt [2] = '{3, 1};
  logic [7:0] hist [2][1024];
  logic [7:0] rawh [2][1024];
  int         nsmp [2];
  logic [7:0] mout [2];
  logic [7:0] mrise [2];
  logic [7:0] mfall [2];
  logic       many [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      nsmp[d]  = 0;
      mout[d]  = 8'h00;
      mrise[d] = 8'h00;
      mfall[d] = 8'h00;
      many[d]  = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("a_sync", busA.dataSync, mout[0]);
    check("a_rise", busA.risePulse, mrise[0]);
    check("a_fall", busA.fallPulse, mfall[0]);
    check("a_any", busA.anyChange, many[0]);
    check("b_sync", {4'h0, busB.dataSync}, mout[1]);
    check("b_rise", {4'h0, busB.risePulse}, mrise[1]);
    check("b_fall", {4'h0, busB.fallPulse}, mfall[1]);
    check("b_any", busB.anyChange, many[1]);
  endtask

  task automatic tick();
    logic [7:0] din [2];
    logic [7:0] raw;
    logic [7:0] upd;
    int         n;
    @(posedge clkRx);
    din[0] = dataA;
    din[1] = {4'h0, dataB};
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        model_reset();
      end else if (!enb) begin
        mrise[d] = 8'h00;
        mfall[d] = 8'h00;
        many[d]  = 1'b0;
      end else begin
        n   = nsmp[d];
        // The synchroniser output seen at this edge is the input from STAGES edges ago.
        raw = (n >= stg[d]) ? hist[d][(n - stg[d]) & HMASK] : 8'h00;
        hist[d][n & HMASK] = din[d];
        rawh[d][n & HMASK] = raw;
        nsmp[d] = n + 1;
        upd = 8'h00;
        if (nsmp[d] >= flt[d]) begin
          upd = 8'hFF;
          for (int j = 1; j <= flt[d]; j++) begin
            upd = upd & (rawh[d][(nsmp[d] - j) & HMASK] ^ mout[d]);
          end
        end
        mrise[d] = upd & ~mout[d];
        mfall[d] = upd & mout[d];
        many[d]  = |upd;
        mout[d]  = mout[d] ^ upd;
      end
    end
    #1;
    compare_all();
  endtask

  // Pulse reset between edges and confirm the asynchronous clear took effect at once.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_a_sync", busA.dataSync, 8'h00);
    check("rst_a_rise", busA.risePulse, 8'h00);
    check("rst_a_fall", busA.fallPulse, 8'h00);
    check("rst_a_any", busA.anyChange, 1'b0);
    check("rst_b_sync", {4'h0, busB.dataSync}, 8'h00);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int nrise;
    int nfall;
    int nhigh;
    logic [7:0] m8;
    logic [3:0] m4;

    model_reset();
    dataA = 8'hFF;
    dataB = 4'h0;
    enb   = 1'b1;
    do_reset();

    // Reset release: full latency of 5 edges
    for (int e = 1; e <= 4; e++) begin
      tick();
      check("init_hold", busA.dataSync, 8'h00);
    end
    tick();
    check("init_sync", busA.dataSync, 8'hFF);
    check("init_rise", busA.risePulse, 8'hFF);
    check("init_any", busA.anyChange, 1'b1);
    tick();
    check("init_rise_drop", busA.risePulse, 8'h00);
    check("init_any_drop", busA.anyChange, 1'b0);

    // Single-bit step
    dataA = 8'h00;
    ticks(6);
    dataA = 8'h08;
    ticks(4);
    check("step_hold", busA.dataSync, 8'h00);
    tick();
    check("step_sync", busA.dataSync, 8'h08);
    check("step_rise", busA.risePulse, 8'h08);
    tick();
    check("step_rise_drop", busA.risePulse, 8'h00);

    // Glitch shorter than FILTER is swallowed
    dataA = 8'h00;
    ticks(6);
    dataA = 8'h01;
    ticks(2);
    dataA = 8'h00;
    for (int e = 0; e < 8; e++) begin
      tick();
      check("glitch_sync", busA.dataSync, 8'h00);
      check("glitch_any", busA.anyChange, 1'b0);
    end

    // Exactly FILTER cycles high is passed through
    nrise = 0;
    nfall = 0;
    nhigh = 0;
    dataA = 8'h01;
    for (int e = 0; e < 13; e++) begin
      if (e == 3) dataA = 8'h00;
      tick();
      nrise += int'(busA.risePulse[0]);
      nfall += int'(busA.fallPulse[0]);
      nhigh += int'(busA.dataSync[0]);
    end
    check("pulse3_rises", nrise, 1);
    check("pulse3_falls", nfall, 1);
    check("pulse3_high", nhigh, 3);

    // Enable gating after the count has started
    dataA = 8'h10;
    ticks(3);
    enb = 1'b0;
    for (int e = 0; e < 4; e++) begin
      tick();
      check("gate_sync", busA.dataSync, 8'h00);
      check("gate_any", busA.anyChange, 1'b0);
    end
    enb = 1'b1;
    tick();
    check("gate_resume1", busA.dataSync, 8'h00);
    tick();
    check("gate_resume2", busA.dataSync, 8'h10);
    check("gate_rise", busA.risePulse, 8'h10);

    // Reset in the middle of a count restarts the full latency
    dataA = 8'h00;
    ticks(6);
    dataA = 8'h80;
    ticks(3);
    do_reset();
    for (int e = 1; e <= 4; e++) begin
      tick();
      check("midrst_hold", busA.dataSync, 8'h00);
    end
    tick();
    check("midrst_sync", busA.dataSync, 8'h80);

    // STAGES=3, FILTER=1 configuration: two channels together, 4-edge latency
    dataB = 4'b0101;
    ticks(3);
    check("sweep_hold", {4'h0, busB.dataSync}, 8'h00);
    tick();
    check("sweep_sync", {4'h0, busB.dataSync}, 8'h05);
    check("sweep_rise", {4'h0, busB.risePulse}, 8'h05);
    check("sweep_any", busB.anyChange, 1'b1);

    // Random stimulus against the model
    for (int c = 0; c < 400; c++) begin
      m8 = 8'h00;
      m4 = 4'h0;
      for (int b = 0; b < 8; b++) m8[b] = ($urandom_range(0, 4) == 0);
      for (int b = 0; b < 4; b++) m4[b] = ($urandom_range(0, 3) == 0);
      dataA = dataA ^ m8;
      dataB = dataB ^ m4;
      enb   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 79) == 0) do_reset();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
